// File: rtl/mae_mac_model.sv
`default_nettype none
// mae_mac_model: cycle-accurate model of the MAE 18x18 signed multiply-accumulate
// macro with optional A/B input registers, 40-bit accumulator and P output register.
module mae_mac_model #(
   parameter int BYPASS_A = 0,
   parameter int BYPASS_B = 0,
   parameter int BYPASS_C = 0,
   parameter int BYPASS_P = 0
) (
   input  logic               CLK,
   input  logic               ARST_N,
   input  logic signed [17:0] A,
   input  logic               A_EN,
   input  logic               A_SRST_N,
   input  logic signed [17:0] B,
   input  logic               B_EN,
   input  logic               B_SRST_N,
   input  logic               ACC,
   input  logic               C_SRST_N,
   input  logic               P_EN,
   input  logic               P_SRST_N,
   output logic signed [39:0] P
);

   logic signed [17:0] a_r;
   logic signed [17:0] b_r;
   logic signed [39:0] m;
   logic signed [39:0] s;
   logic signed [39:0] c_r;
   logic               acc_sel;

   generate
      if (BYPASS_A != 0) begin : g_a_bypass
         logic unused_a;
         assign unused_a = ^{A_EN, A_SRST_N};
         assign a_r = A;
      end else begin : g_a_reg
         logic signed [17:0] a_q;
         always_ff @(posedge CLK or negedge ARST_N) begin
            if (!ARST_N)        a_q <= '0;
            else if (!A_SRST_N) a_q <= '0;
            else if (A_EN)      a_q <= A;
         end
         assign a_r = a_q;
      end

      if (BYPASS_B != 0) begin : g_b_bypass
         logic unused_b;
         assign unused_b = ^{B_EN, B_SRST_N};
         assign b_r = B;
      end else begin : g_b_reg
         logic signed [17:0] b_q;
         always_ff @(posedge CLK or negedge ARST_N) begin
            if (!ARST_N)        b_q <= '0;
            else if (!B_SRST_N) b_q <= '0;
            else if (B_EN)      b_q <= B;
         end
         assign b_r = b_q;
      end
   endgenerate

   // The 36-bit product always fits, so the low 40 bits of the widened product
   // are the sign-extended result.
   assign m       = 40'(a_r) * 40'(b_r);
   assign acc_sel = ACC && (BYPASS_C == 0);
   assign s       = m + (acc_sel ? c_r : 40'sd0);

   generate
      if (BYPASS_C != 0) begin : g_c_bypass
         logic unused_c;
         assign unused_c = ^{C_SRST_N, ACC};
         assign c_r = '0;
      end else begin : g_c_reg
         logic signed [39:0] c_q;
         always_ff @(posedge CLK or negedge ARST_N) begin
            if (!ARST_N)        c_q <= '0;
            else if (!C_SRST_N) c_q <= '0;
            else if (P_EN)      c_q <= s;
         end
         assign c_r = c_q;
      end

      if (BYPASS_P != 0) begin : g_p_bypass
         logic unused_p;
         assign unused_p = ^{P_SRST_N, P_EN};
         assign P = s;
      end else begin : g_p_reg
         logic signed [39:0] p_q;
         always_ff @(posedge CLK or negedge ARST_N) begin
            if (!ARST_N)        p_q <= '0;
            else if (!P_SRST_N) p_q <= '0;
            else if (P_EN)      p_q <= s;
         end
         assign P = p_q;
      end
   endgenerate

endmodule
`default_nettype wire

// File: doc/mae_mac_model.md
# mae_mac_model

Cycle-accurate behavioural model of the MAE hard multiply-accumulate macro, the target cell that synthesis maps DSP inference onto. It is an 18x18 signed multiplier with optional A/B input registers, a 40-bit accumulator (C) register and an optional P output register, each with its own enable and synchronous clear. It is used as the simulation model behind the mapped netlist and as the golden model in DSP equivalence benches.

## Interface
Parameters:
- BYPASS_A, default 0: 1 makes A combinational; 0 registers it.
- BYPASS_B, default 0: 1 makes B combinational; 0 registers it.
- BYPASS_C, default 0: 1 disables the accumulator so the sum is the product only; 0 enables it.
- BYPASS_P, default 0: 1 makes P combinational from the sum; 0 registers it.

Ports:
- CLK  in  1  single clock, rising edge
- ARST_N  in  1  asynchronous active-low reset for all registers
- A  in  18  signed multiplicand
- A_EN  in  1  A register load enable
- A_SRST_N  in  1  A register synchronous clear, active-low
- B  in  18  signed multiplier
- B_EN  in  1  B register load enable
- B_SRST_N  in  1  B register synchronous clear, active-low
- ACC  in  1  1 adds the accumulator into the sum; 0 sums the product only
- C_SRST_N  in  1  accumulator synchronous clear, active-low
- P_EN  in  1  load enable for both the accumulator and the P register
- P_SRST_N  in  1  P register synchronous clear, active-low
- P  out  40  signed result

## Operation
- A_r is A when BYPASS_A=1. Otherwise it is a register: async clear on ARST_N=0; else on CLK, A_SRST_N=0 gives 0; else A_EN=1 loads A; else it holds. B_r follows the same rules with the B signals.
- M = signed(A_r) x signed(B_r), 36 bits, sign-extended to 40.
- S = M + (ACC && !BYPASS_C ? C_r : 0), modulo 2^40. Wrap is silent, with no saturation or flag.
- C_r, when BYPASS_C=0: async clear; else on CLK, C_SRST_N=0 gives 0; else P_EN=1 loads S; else it holds. When BYPASS_C=1, C_r is held at 0.
- P_r, when BYPASS_P=0: async clear; else on CLK, P_SRST_N=0 gives 0; else P_EN=1 loads S; else it holds. P = P_r.
- When BYPASS_P=1, P = S combinationally.
- In every register, synchronous clear has priority over enable. An enable with no clear is the only way to load.
- With BYPASS_P=1 and BYPASS_C=0, P is C_r + M before the edge, which is the next accumulator value.

## Timing
- Reset values: A_r, B_r, C_r and P_r are all 0.
  - P is 0 during reset when BYPASS_P=0.
  - With BYPASS_P=1, P is the combinational product of the bypassed inputs and any cleared registers.
- Latency from A/B to P is (BYPASS_A&&BYPASS_B ? 0 : 1) + (BYPASS_P ? 0 : 1) cycles. Default is 2.
- Accumulator feedback latency is 1 cycle: the sample loaded at edge k is included in S from edge k onward.
- ARST_N assertion mid-operation clears all registers immediately, not at the next edge. Deassertion takes effect at the first CLK edge where ARST_N=1.
- A/B enables are independent. A held register feeds the same operand into every subsequent sum, so repeated accumulation is legal.
- No handshake. The caller tracks latency; P_EN=0 stalls both the accumulator and P.

## Test plan
- Default params, reset release, A=3, B=-5, all enables=1, ACC=0 -> P=-15 (40'hFF_FFFF_FFF1) two edges later. P is 0 before that.
- A=-131072, B=-131072, ACC=1, all enables=1, 33 edges after reset -> P steps by 2^34 per cycle once the pipe fills. The 32nd accumulated value wraps to 40'h80_0000_0000.
- Accumulate A=10, B=10 over 4 cycles (P=400), then P_EN=0 for 3 cycles -> P holds 400. Then C_SRST_N=0 with P_EN=1 for 1 cycle, ACC=1 -> the accumulator restarts and P returns to 100 on the following edges.
- A_SRST_N=0 and A_EN=1 on the same edge, A=7 -> A_r=0. P becomes 0 after the P stage.
- BYPASS_A=BYPASS_B=BYPASS_P=1, BYPASS_C=1, A=100, B=-2 -> P=-200 in the same cycle with no clock edge.
- ARST_N pulsed low between edges during accumulation at P=1234 -> P=0 immediately and stays 0 until fresh data propagates.
